// File: rtl/vga_sram_arbiter_if.sv
// Request/response channel shared by the CPU, VGA and SRAM-controller sides of the arbiter.
// A master holds valid/we/addr/wdata until the slave answers with ready and rdata.
interface vga_sram_arbiter_if;
    logic        valid;
    logic        we;
    logic [18:0] addr;
    logic [15:0] wdata;
    logic        ready;
    logic [15:0] rdata;

    modport master (
        output valid,
        output we,
        output addr,
        output wdata,
        input  ready,
        input  rdata
    );

    modport slave (
        input  valid,
        input  we,
        input  addr,
        input  wdata,
        output ready,
        output rdata
    );
endinterface

// File: rtl/vga_sram_arbiter.sv
// Two-master SRAM arbiter: VGA framebuffer fetch has priority, but a waiting CPU is served after
// STARVE_LIMIT consecutive VGA grants. Exactly one access is outstanding at a time.
module vga_sram_arbiter #(
    parameter logic [2:0] STARVE_LIMIT = 3'd4
) (
    input  logic               clk,
    input  logic               resetn,
    vga_sram_arbiter_if.slave  cpu,
    vga_sram_arbiter_if.slave  vga,
    vga_sram_arbiter_if.master mem
);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e      state_q;
    logic        owner_q;
    logic [2:0]  starve_cnt_q;
    logic        mem_valid_q;
    logic        mem_we_q;
    logic [18:0] mem_addr_q;
    logic [15:0] mem_wdata_q;
    logic        cpu_ready_q;
    logic        vga_ready_q;
    logic [15:0] cpu_rdata_q;
    logic [15:0] vga_rdata_q;
    logic        grant_vga;

    // VGA wins a collision until the CPU has waited through STARVE_LIMIT VGA grants.
    always_comb begin
        grant_vga = vga.valid && (!cpu.valid || (starve_cnt_q < STARVE_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            starve_cnt_q <= 3'd0;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 19'd0;
            mem_wdata_q  <= 16'd0;
            cpu_ready_q  <= 1'b0;
            vga_ready_q  <= 1'b0;
            cpu_rdata_q  <= 16'd0;
            vga_rdata_q  <= 16'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (cpu.valid || vga.valid) begin
                        owner_q     <= grant_vga;
                        mem_valid_q <= 1'b1;
                        mem_we_q    <= grant_vga ? vga.we    : cpu.we;
                        mem_addr_q  <= grant_vga ? vga.addr  : cpu.addr;
                        mem_wdata_q <= grant_vga ? vga.wdata : cpu.wdata;
                        if (!grant_vga) begin
                            starve_cnt_q <= 3'd0;
                        end else if (cpu.valid && (starve_cnt_q != 3'd7)) begin
                            starve_cnt_q <= starve_cnt_q + 3'd1;
                        end
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (mem.ready) begin
                        mem_valid_q <= 1'b0;
                        if (owner_q) begin
                            vga_ready_q <= 1'b1;
                            if (!mem_we_q) vga_rdata_q <= mem.rdata;
                        end else begin
                            cpu_ready_q <= 1'b1;
                            if (!mem_we_q) cpu_rdata_q <= mem.rdata;
                        end
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    // No grant here, so a master still holding valid in its ready cycle waits.
                    cpu_ready_q <= 1'b0;
                    vga_ready_q <= 1'b0;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem.valid = mem_valid_q;
    assign mem.we    = mem_we_q;
    assign mem.addr  = mem_addr_q;
    assign mem.wdata = mem_wdata_q;
    assign cpu.ready = cpu_ready_q;
    assign cpu.rdata = cpu_rdata_q;
    assign vga.ready = vga_ready_q;
    assign vga.rdata = vga_rdata_q;

endmodule

// File: tb/tb_vga_sram_arbiter.sv
// Directed bench for vga_sram_arbiter: DUT a uses the default starvation limit, DUT b uses 0.
module tb_vga_sram_arbiter;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    vga_sram_arbiter_if cpu_a ();
    vga_sram_arbiter_if vga_a ();
    vga_sram_arbiter_if mem_a ();
    vga_sram_arbiter_if cpu_b ();
    vga_sram_arbiter_if vga_b ();
    vga_sram_arbiter_if mem_b ();

    vga_sram_arbiter dut_a (
        .clk    (clk),
        .resetn (resetn),
        .cpu    (cpu_a),
        .vga    (vga_a),
        .mem    (mem_a)
    );

    vga_sram_arbiter #(.STARVE_LIMIT(3'd0)) dut_b (
        .clk    (clk),
        .resetn (resetn),
        .cpu    (cpu_b),
        .vga    (vga_b),
        .mem    (mem_b)
    );

    int total = 0;
    int bad   = 0;

    // SRAM model for dut a: ready after lat BUSY cycles without ready.
    int          lat = 0;
    int          wait_cnt = 0;
    logic        auto_rdy = 1'b0;
    logic        man_rdy = 1'b0;
    logic [15:0] rdata_tb = 16'd0;
    assign mem_a.ready = auto_rdy | man_rdy;
    assign mem_a.rdata = rdata_tb;

    always @(posedge clk) begin
        #2;
        if (mem_a.valid === 1'b1) begin
            if (wait_cnt >= lat) begin
                auto_rdy = 1'b1;
            end else begin
                auto_rdy = 1'b0;
                wait_cnt++;
            end
        end else begin
            auto_rdy = 1'b0;
            wait_cnt = 0;
        end
    end

    logic rdy_b = 1'b0;
    assign mem_b.ready = rdy_b;
    assign mem_b.rdata = 16'hC0DE;
    always @(posedge clk) begin
        #2;
        rdy_b = (mem_b.valid === 1'b1);
    end

    // Grant log (1 = VGA) recorded from ready pulses, plus access/ready counters.
    bit   log_a[$];
    bit   log_b[$];
    int   acc_a = 0;
    int   rdy_a = 0;
    int   both_rdy = 0;
    logic mv_prev = 1'b0;
    always @(negedge clk) begin
        if (cpu_a.ready === 1'b1 && vga_a.ready === 1'b1) both_rdy++;
        if (cpu_b.ready === 1'b1 && vga_b.ready === 1'b1) both_rdy++;
        if (cpu_a.ready === 1'b1) log_a.push_back(1'b0);
        if (vga_a.ready === 1'b1) log_a.push_back(1'b1);
        if (cpu_b.ready === 1'b1) log_b.push_back(1'b0);
        if (vga_b.ready === 1'b1) log_b.push_back(1'b1);
        if (cpu_a.ready === 1'b1 || vga_a.ready === 1'b1) rdy_a++;
        if (mem_a.valid === 1'b1 && mv_prev !== 1'b1) acc_a++;
        mv_prev = mem_a.valid;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int  n;
        int  base;
        int  acc0;
        int  rdy0;
        bit  exp_seq[10];
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        resetn = 1'b0;
        cpu_a.valid = 1'b0; cpu_a.we = 1'b0; cpu_a.addr = '0; cpu_a.wdata = '0;
        vga_a.valid = 1'b0; vga_a.we = 1'b0; vga_a.addr = '0; vga_a.wdata = '0;
        cpu_b.valid = 1'b0; cpu_b.we = 1'b0; cpu_b.addr = '0; cpu_b.wdata = '0;
        vga_b.valid = 1'b0; vga_b.we = 1'b0; vga_b.addr = '0; vga_b.wdata = '0;
        tick(2);
        chk("rst_mem_valid", mem_a.valid, 0);
        chk("rst_mem_we", mem_a.we, 0);
        chk("rst_mem_addr", mem_a.addr, 0);
        chk("rst_mem_wdata", mem_a.wdata, 0);
        chk("rst_cpu_ready", cpu_a.ready, 0);
        chk("rst_vga_ready", vga_a.ready, 0);
        chk("rst_cpu_rdata", cpu_a.rdata, 0);
        chk("rst_vga_rdata", vga_a.rdata, 0);

        // CPU read presented while reset still held: granted only once resetn is high.
        cpu_a.valid = 1'b1; cpu_a.we = 1'b0; cpu_a.addr = 19'h12345; rdata_tb = 16'hBEEF;
        tick(1);
        chk("no_grant_in_reset", mem_a.valid, 0);
        resetn = 1'b1;
        tick(1);
        chk("cpu_rd_mem_valid", mem_a.valid, 1);
        chk("cpu_rd_mem_addr", mem_a.addr, 19'h12345);
        chk("cpu_rd_mem_we", mem_a.we, 0);
        chk("cpu_rd_ready_early", cpu_a.ready, 0);
        tick(1);
        chk("cpu_rd_ready", cpu_a.ready, 1);
        chk("cpu_rd_rdata", cpu_a.rdata, 16'hBEEF);
        chk("cpu_rd_vga_ready", vga_a.ready, 0);
        chk("cpu_rd_mem_drop", mem_a.valid, 0);
        cpu_a.valid = 1'b0;
        tick(1);
        chk("cpu_rd_ready_pulse", cpu_a.ready, 0);
        chk("cpu_rd_rdata_hold", cpu_a.rdata, 16'hBEEF);

        // Stray mem_ready while idle.
        man_rdy = 1'b1;
        tick(2);
        chk("stray_cpu_ready", cpu_a.ready, 0);
        chk("stray_vga_ready", vga_a.ready, 0);
        chk("stray_mem_valid", mem_a.valid, 0);
        man_rdy = 1'b0;

        // VGA write with 5 stalled BUSY cycles; master inputs change mid-access.
        lat = 5; rdata_tb = 16'hDEAD;
        vga_a.valid = 1'b1; vga_a.we = 1'b1; vga_a.addr = 19'h30000; vga_a.wdata = 16'h00E3;
        tick(1);
        chk("vga_wr_mem_valid", mem_a.valid, 1);
        chk("vga_wr_mem_we", mem_a.we, 1);
        chk("vga_wr_mem_addr", mem_a.addr, 19'h30000);
        chk("vga_wr_mem_wdata", mem_a.wdata, 16'h00E3);
        vga_a.addr = 19'h7FFFF; vga_a.wdata = 16'hFFFF; vga_a.we = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("vga_wr_hold_valid", mem_a.valid, 1);
            chk("vga_wr_hold_we", mem_a.we, 1);
            chk("vga_wr_hold_addr", mem_a.addr, 19'h30000);
            chk("vga_wr_hold_wdata", mem_a.wdata, 16'h00E3);
            chk("vga_wr_no_ready", vga_a.ready, 0);
        end
        tick(1);
        chk("vga_wr_ready", vga_a.ready, 1);
        chk("vga_wr_rdata_kept", vga_a.rdata, 0);
        chk("vga_wr_cpu_ready", cpu_a.ready, 0);
        chk("vga_wr_mem_drop", mem_a.valid, 0);
        vga_a.valid = 1'b0;
        tick(1);
        chk("vga_wr_ready_pulse", vga_a.ready, 0);

        // Reset during a CPU access, then re-grant of the still-held request.
        lat = 3; rdata_tb = 16'h1234;
        cpu_a.valid = 1'b1; cpu_a.we = 1'b0; cpu_a.addr = 19'h00ABC;
        tick(1);
        chk("rst_busy_granted", mem_a.valid, 1);
        resetn = 1'b0;
        tick(1);
        chk("rst_busy_mem_drop", mem_a.valid, 0);
        chk("rst_busy_no_ready", cpu_a.ready, 0);
        chk("rst_busy_rdata_clr", cpu_a.rdata, 0);
        resetn = 1'b1;
        tick(1);
        chk("rst_regrant_valid", mem_a.valid, 1);
        chk("rst_regrant_addr", mem_a.addr, 19'h00ABC);
        n = 0;
        while (cpu_a.ready !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        chk("rst_regrant_ready", cpu_a.ready, 1);
        chk("rst_regrant_rdata", cpu_a.rdata, 16'h1234);
        cpu_a.valid = 1'b0;
        tick(1);

        // VGA holds valid through its ready cycle: no re-grant from RESP.
        acc0 = acc_a; rdy0 = rdy_a;
        lat = 0; rdata_tb = 16'h5555;
        vga_a.valid = 1'b1; vga_a.we = 1'b0; vga_a.addr = 19'h00100;
        tick(1);
        chk("hold_granted", mem_a.valid, 1);
        tick(1);
        chk("hold_ready", vga_a.ready, 1);
        chk("hold_rdata", vga_a.rdata, 16'h5555);
        tick(1);
        chk("hold_no_regrant", mem_a.valid, 0);
        chk("hold_ready_pulse", vga_a.ready, 0);
        vga_a.valid = 1'b0;
        tick(1);
        chk("hold_idle", mem_a.valid, 0);
        tick(1);
        chk("hold_acc_cnt", acc_a - acc0, 1);
        chk("hold_rdy_cnt", rdy_a - rdy0, 1);

        // Continuous collisions with STARVE_LIMIT=4.
        base = log_a.size();
        rdata_tb = 16'hA5A5;
        cpu_a.valid = 1'b1; cpu_a.we = 1'b0; cpu_a.addr = 19'h11111;
        vga_a.valid = 1'b1; vga_a.we = 1'b0; vga_a.addr = 19'h22222;
        n = 0;
        while (log_a.size() < base + 10 && n < 80) begin
            tick(1);
            n++;
        end
        cpu_a.valid = 1'b0;
        vga_a.valid = 1'b0;
        chk("coll_grant_cnt", log_a.size() - base, 10);
        for (int i = 0; i < 10; i++) begin
            if (base + i < log_a.size()) chk("coll_order", log_a[base+i], exp_seq[i]);
        end
        chk("coll_cpu_rdata", cpu_a.rdata, 16'hA5A5);
        chk("coll_vga_rdata", vga_a.rdata, 16'hA5A5);
        tick(2);
        chk("coll_idle", mem_a.valid, 0);
        chk("acc_cnt_total", acc_a - acc0, 11);
        chk("rdy_cnt_total", rdy_a - rdy0, 11);

        // STARVE_LIMIT=0: CPU wins every collision; VGA served once the CPU stops.
        base = log_b.size();
        cpu_b.valid = 1'b1; cpu_b.addr = 19'h00001;
        vga_b.valid = 1'b1; vga_b.addr = 19'h00002;
        n = 0;
        while (log_b.size() < base + 3 && n < 40) begin
            tick(1);
            n++;
        end
        cpu_b.valid = 1'b0;
        n = 0;
        while (log_b.size() < base + 4 && n < 20) begin
            tick(1);
            n++;
        end
        vga_b.valid = 1'b0;
        chk("lim0_grant_cnt", log_b.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < log_b.size()) chk("lim0_order", log_b[base+i], (i == 3) ? 1 : 0);
        end
        chk("lim0_vga_rdata", vga_b.rdata, 16'hC0DE);
        tick(2);

        chk("never_both_ready", both_rdy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
